// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the 3x3 MAC sequencer.
// Column layout: one 8-bit lane per row, weights in the low nibble.
package mac_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int PIX_W = 8;
  localparam int WGT_W = 4;
  localparam int ROWS  = 3;

  localparam int IMG_ROW1_LSB = 0;
  localparam int IMG_ROW2_LSB = 8;
  localparam int IMG_ROW3_LSB = 16;
  localparam int WGT_ROW1_LSB = 0;
  localparam int WGT_ROW2_LSB = 8;
  localparam int WGT_ROW3_LSB = 16;

  localparam int IMG_STRIDE = IMG_ROW2_LSB - IMG_ROW1_LSB;
  localparam int WGT_STRIDE = WGT_ROW2_LSB - WGT_ROW1_LSB;

  function automatic logic [PIX_W-1:0] img_row(
    input logic [23:0] col,
    input int          r
  );
    return col[IMG_ROW1_LSB + r*IMG_STRIDE +: PIX_W];
  endfunction

  function automatic logic [WGT_W-1:0] wgt_row(
    input logic [23:0] col,
    input int          r
  );
    return col[WGT_ROW1_LSB + r*WGT_STRIDE +: WGT_W];
  endfunction

endpackage

// File: rtl/mac_win_shift.sv
// 3x3 pixel/weight sliding window; each row shifts toward index 1
// when a new column is captured, newest column lands in the third slot.
module mac_win_shift
  import mac_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_shift,
  input  logic [23:0] i_img_col,
  input  logic [23:0] i_wgt_col,
  output logic [71:0] o_im_win,
  output logic [35:0] o_ker_win
);

  localparam int IRW = 3*PIX_W;
  localparam int KRW = 3*WGT_W;

  logic [71:0] im_q, im_d;
  logic [35:0] ker_q, ker_d;

  always_comb begin
    im_d  = im_q;
    ker_d = ker_q;
    if (i_shift) begin
      for (int r = 0; r < ROWS; r++) begin
        im_d[r*IRW +: IRW] =
          {img_row(i_img_col, r), im_q[r*IRW+PIX_W +: 2*PIX_W]};
        ker_d[r*KRW +: KRW] =
          {wgt_row(i_wgt_col, r), ker_q[r*KRW+WGT_W +: 2*WGT_W]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      im_q  <= '0;
      ker_q <= '0;
    end else begin
      im_q  <= im_d;
      ker_q <= ker_d;
    end
  end

  assign o_im_win  = im_q;
  assign o_ker_win = ker_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Fetch/window/write sequencer that drives the 3x3 mac datapath
// from a packed 3-row column buffer and stores its results.
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 17,
  parameter int DRAIN_MAX = 64,
  parameter int CYC_W     = 32
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_n,
  input  logic              i_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [23:0]       i_img_data,
  input  logic [23:0]       i_wgt_data,
  output logic [71:0]       o_im_win,
  output logic [35:0]       o_ker_win,
  output logic              o_mac_valid,
  input  logic              i_mac_valid,
  input  logic [15:0]       i_mac_conv,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic [CYC_W-1:0]  o_cycles
);

  localparam int DW = $clog2(DRAIN_MAX + 1);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_vld_q, rd_vld_d;
  logic              mac_vld_q, mac_vld_d;
  logic              err_q, err_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [DW-1:0]     drn_q, drn_d;

  logic              rd_en;
  logic              run;
  logic [ADDR_W-1:0] n_m2;

  assign rd_en = (state_q == ST_FETCH) && !i_hold;
  assign run   = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign n_m2  = n_q - ADDR_W'(2);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    addr_d    = addr_q;
    col_d     = col_q;
    wr_cnt_d  = wr_cnt_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    rd_vld_d  = rd_en;
    mac_vld_d = rd_vld_q && (col_q >= ADDR_W'(2));
    err_d     = err_q;
    cyc_d     = cyc_q;
    drn_d     = drn_q;

    if (rd_en)
      addr_d = addr_q + ADDR_W'(1);
    if (rd_vld_q)
      col_d = col_q + ADDR_W'(1);
    if (state_q != ST_IDLE)
      cyc_d = cyc_q + CYC_W'(1);

    // Results beyond the expected window count are flagged, not stored.
    if (run && i_mac_valid) begin
      if (wr_cnt_q == n_m2) begin
        err_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = wr_cnt_q;
        wr_data_d = i_mac_conv;
        wr_cnt_d  = wr_cnt_q + ADDR_W'(1);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_n >= ADDR_W'(3)) begin
            state_d  = ST_FETCH;
            n_d      = i_n;
            addr_d   = '0;
            col_d    = '0;
            wr_cnt_d = '0;
            cyc_d    = '0;
            drn_d    = '0;
            err_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (rd_en && (addr_q == n_q - ADDR_W'(1))) begin
          state_d = ST_DRAIN;
          drn_d   = '0;
        end
      end
      ST_DRAIN: begin
        drn_d = drn_q + DW'(1);
        if (wr_cnt_q == n_m2) begin
          state_d = ST_DONE;
        end else if (drn_q == DW'(DRAIN_MAX - 1)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      addr_q    <= '0;
      col_q     <= '0;
      wr_cnt_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      mac_vld_q <= 1'b0;
      err_q     <= 1'b0;
      cyc_q     <= '0;
      drn_q     <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      addr_q    <= addr_d;
      col_q     <= col_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      rd_vld_q  <= rd_vld_d;
      mac_vld_q <= mac_vld_d;
      err_q     <= err_d;
      cyc_q     <= cyc_d;
      drn_q     <= drn_d;
    end
  end

  mac_win_shift u_win (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_shift   (rd_vld_q),
    .i_img_col (i_img_data),
    .i_wgt_col (i_wgt_data),
    .o_im_win  (o_im_win),
    .o_ker_win (o_ker_win)
  );

  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_err       = err_q;
  assign o_rd_en     = rd_en;
  assign o_rd_addr   = addr_q;
  assign o_mac_valid = mac_vld_q;
  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_cycles    = cyc_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a column memory and a
// fixed-latency-3 MAC model; outputs sampled on the falling edge.
module tb_mac_seq_ctrl;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_n = '0;
  logic          i_hold = 1'b0;
  logic          o_busy, o_done, o_err, o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic [23:0]   i_img_data = '0;
  logic [23:0]   i_wgt_data = '0;
  logic [71:0]   o_im_win;
  logic [35:0]   o_ker_win;
  logic          o_mac_valid;
  logic          i_mac_valid;
  logic [15:0]   i_mac_conv;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [15:0]   o_wr_data;
  logic [31:0]   o_cycles;

  int n_vec = 0;
  int n_err = 0;
  bit mac_on = 1'b1;

  logic [2:0]  mv_p = '0;
  logic [15:0] cv_p [3];

  always #5 clk = ~clk;

  mac_seq_ctrl dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_n         (i_n),
    .i_hold      (i_hold),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_rd_en     (o_rd_en),
    .o_rd_addr   (o_rd_addr),
    .i_img_data  (i_img_data),
    .i_wgt_data  (i_wgt_data),
    .o_im_win    (o_im_win),
    .o_ker_win   (o_ker_win),
    .o_mac_valid (o_mac_valid),
    .i_mac_valid (i_mac_valid),
    .i_mac_conv  (i_mac_conv),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_cycles    (o_cycles)
  );

  // Column k holds k in every row lane.
  always @(posedge clk) begin
    if (o_rd_en) begin
      i_img_data <= {3{o_rd_addr[7:0]}};
      i_wgt_data <= {3{4'h0, o_rd_addr[3:0]}};
    end
  end

  function automatic logic [15:0] dot9(
    input logic [71:0] im,
    input logic [35:0] kr
  );
    logic [15:0] s = '0;
    for (int p = 0; p < 9; p++)
      s += 16'(im[p*8 +: 8]) * 16'(kr[p*4 +: 4]);
    return s;
  endfunction

  always @(posedge clk) begin
    mv_p     <= {mv_p[1:0], o_mac_valid & mac_on};
    cv_p[0]  <= dot9(o_im_win, o_ker_win);
    cv_p[1]  <= cv_p[0];
    cv_p[2]  <= cv_p[1];
  end
  assign i_mac_valid = mv_p[2];
  assign i_mac_conv  = cv_p[2];

  task automatic chk(
    input string       tag,
    input logic [71:0] got,
    input logic [71:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start(input int n);
    @(negedge clk);
    i_n     = AW'(n);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run(
    input int n,
    input bit hold,
    input int e_fmv,
    input int e_lmv,
    input int e_gap,
    input int e_fwr,
    input int e_nwr,
    input int e_done,
    input bit e_err
  );
    int rd = 0, mv = 0, wr = 0;
    int fmv = -1, lmv = -1, gap = 0, fwr = -1, dn = -1;
    int j;
    start(n);
    for (int k = 0; k < 200 && dn < 0; k++) begin
      i_hold = hold && (k >= 4) && (k <= 6);
      #1;
      if (o_rd_en) begin
        chk("rd_addr", 72'(o_rd_addr), 72'(rd));
        rd++;
      end
      if (o_mac_valid) begin
        if (fmv < 0) begin
          fmv = k;
          chk("im_win", o_im_win, 72'h020100020100020100);
          chk("ker_win", 72'(o_ker_win), 72'h210210210);
        end
        if (lmv >= 0 && k - lmv - 1 > gap) gap = k - lmv - 1;
        lmv = k;
        mv++;
      end
      if (o_wr_en) begin
        if (fwr < 0) fwr = k;
        j = wr;
        chk("wr_addr", 72'(o_wr_addr), 72'(j));
        chk("wr_data", 72'(o_wr_data),
            72'(3*(j*j + (j+1)*(j+1) + (j+2)*(j+2))));
        wr++;
      end
      if (o_done) dn = k;
      @(negedge clk);
    end
    i_hold = 1'b0;
    chk("rd_cnt", 72'(rd), 72'(n));
    chk("mv_first", 72'(fmv), 72'(e_fmv));
    chk("mv_last", 72'(lmv), 72'(e_lmv));
    chk("mv_gap", 72'(gap), 72'(e_gap));
    chk("wr_first", 72'(fwr), 72'(e_fwr));
    chk("wr_cnt", 72'(wr), 72'(e_nwr));
    chk("done_at", 72'(dn), 72'(e_done));
    #1;
    chk("cycles", 72'(o_cycles), 72'(e_done + 1));
    chk("err", 72'(o_err), 72'(e_err));
    chk("busy_end", 72'(o_busy), 72'(0));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 72'(o_busy), 72'(0));
    chk("rst_win", o_im_win, 72'(0));
    chk("rst_cyc", 72'(o_cycles), 72'(0));
    i_rst = 1'b0;
    @(negedge clk);

    run(8, 1'b0, 4, 9, 0, 8, 6, 14, 1'b0);
    run(8, 1'b1, 4, 12, 3, 8, 6, 17, 1'b0);

    start(2);
    for (int k = 0; k < 4; k++) begin
      chk("n2_busy", 72'(o_busy), 72'(0));
      chk("n2_rd", 72'(o_rd_en), 72'(0));
      @(negedge clk);
    end
    chk("n2_err", 72'(o_err), 72'(1));
    run(4, 1'b0, 4, 5, 0, 8, 2, 10, 1'b0);

    mac_on = 1'b0;
    run(8, 1'b0, 4, 9, 0, -1, 0, 72, 1'b1);
    mac_on = 1'b1;
    repeat (4) @(negedge clk);

    start(8);
    for (int k = 0; k < 20 && !(o_rd_en && o_rd_addr == 5); k++)
      @(negedge clk);
    chk("rst_at5", 72'(o_rd_addr), 72'(5));
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    chk("mid_busy", 72'(o_busy), 72'(0));
    chk("mid_rd", 72'(o_rd_en), 72'(0));
    chk("mid_addr", 72'(o_rd_addr), 72'(0));
    chk("mid_mv", 72'(o_mac_valid), 72'(0));
    chk("mid_win", o_im_win, 72'(0));
    chk("mid_ker", 72'(o_ker_win), 72'(0));
    chk("mid_cyc", 72'(o_cycles), 72'(0));
    chk("mid_wr", 72'(o_wr_en), 72'(0));
    chk("mid_err", 72'(o_err), 72'(0));
    repeat (6) @(negedge clk);
    run(8, 1'b0, 4, 9, 0, 8, 6, 14, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
